// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage of the 16-bit RISC core.
// Sits between execute and write-back. Each instruction is either a pure
// ALU op (forwarded to the MEM/WB registers with one cycle of latency) or a
// single data-memory load/store over a req/ack handshake.
//
// Handshake with data memory: dmem_req rises on the edge that accepts a
// memory op and stays high, with dmem_addr/dmem_we/dmem_wdata held stable,
// until dmem_ack is sampled high on a rising edge; that edge completes the
// transaction (dmem_rdata is valid alongside dmem_ack) and drops dmem_req.
// While a transaction is outstanding mem_stall is high and upstream holds
// its outputs; the held instruction is accepted in the first IDLE cycle.
//
// Optional build macro MEM_TIMEOUT_EN: aborts an access after
// TIMEOUT_CYCLES cycles without ack, emits a write-back bubble with
// wb_reg_write forced low and sets the sticky mem_error flag.
// Without the macro the stage waits for ack forever and mem_error is 0.
module mem_access_stage #(
   parameter int DATA_W         = 16,
   parameter int RD_W           = 3,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_mem_to_reg,
   input  logic              ex_reg_write,
   input  logic [RD_W-1:0]   ex_rd,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_read_data_mem,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic              wb_mem_to_reg,
   output logic              wb_reg_write,
   output logic [RD_W-1:0]   wb_rd,
   output logic              mem_error,
   output logic              dbg_state_o
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   state_e state_q, state_d;

   // Memory-side registers
   logic              dmem_req_q, dmem_req_d;
   logic              dmem_we_q, dmem_we_d;
   logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
   logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

   // Control bits captured at acceptance of a memory op
   logic              cap_m2r_q, cap_m2r_d;
   logic              cap_rw_q, cap_rw_d;
   logic [RD_W-1:0]   cap_rd_q, cap_rd_d;
   logic              cap_load_q, cap_load_d;

   // MEM/WB registers
   logic              wb_valid_q, wb_valid_d;
   logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
   logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
   logic              wb_m2r_q, wb_m2r_d;
   logic              wb_rw_q, wb_rw_d;
   logic [RD_W-1:0]   wb_rd_q, wb_rd_d;

   logic is_mem_op;
   assign is_mem_op = ex_mem_read | ex_mem_write;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_error_q, mem_error_d;
   logic             timeout;

   // Abort fires on the last allowed ACCESS cycle only when no ack is present
   assign timeout = (state_q == ST_ACCESS) && !dmem_ack &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ex_valid && is_mem_op) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (dmem_ack) begin
               state_d = ST_IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (timeout) begin
               state_d = ST_IDLE;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM output logic: next values of the memory and MEM/WB registers
   always_comb begin
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      cap_m2r_d    = cap_m2r_q;
      cap_rw_d     = cap_rw_q;
      cap_rd_d     = cap_rd_q;
      cap_load_d   = cap_load_q;
      wb_valid_d   = 1'b0;
      wb_rdata_d   = wb_rdata_q;
      wb_alu_d     = wb_alu_q;
      wb_m2r_d     = wb_m2r_q;
      wb_rw_d      = wb_rw_q;
      wb_rd_d      = wb_rd_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d        = cnt_q;
      mem_error_d  = mem_error_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef MEM_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (ex_valid) begin
               if (is_mem_op) begin
                  // Launch the access; a read+write op behaves as a store
                  dmem_req_d   = 1'b1;
                  dmem_we_d    = ex_mem_write;
                  dmem_addr_d  = ex_alu_result;
                  dmem_wdata_d = ex_store_data;
                  cap_m2r_d    = ex_mem_to_reg;
                  cap_rw_d     = ex_reg_write;
                  cap_rd_d     = ex_rd;
                  cap_load_d   = ex_mem_read & ~ex_mem_write;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_alu_d   = ex_alu_result;
                  wb_m2r_d   = ex_mem_to_reg;
                  wb_rw_d    = ex_reg_write;
                  wb_rd_d    = ex_rd;
               end
            end
         end
         ST_ACCESS: begin
            if (dmem_ack) begin
               // The access address is the instruction's ALU result
               dmem_req_d = 1'b0;
               wb_valid_d = 1'b1;
               wb_alu_d   = dmem_addr_q;
               wb_m2r_d   = cap_m2r_q;
               wb_rw_d    = cap_rw_q;
               wb_rd_d    = cap_rd_q;
               if (cap_load_q) begin
                  wb_rdata_d = dmem_rdata;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (timeout) begin
               // Retire the instruction without a register write
               dmem_req_d  = 1'b0;
               wb_valid_d  = 1'b1;
               wb_alu_d    = dmem_addr_q;
               wb_m2r_d    = cap_m2r_q;
               wb_rw_d     = 1'b0;
               wb_rd_d     = cap_rd_q;
               mem_error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: begin
            dmem_req_d = 1'b0;
         end
      endcase
   end

   // Memory-side, captured-control and MEM/WB registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         cap_m2r_q    <= 1'b0;
         cap_rw_q     <= 1'b0;
         cap_rd_q     <= '0;
         cap_load_q   <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_rdata_q   <= '0;
         wb_alu_q     <= '0;
         wb_m2r_q     <= 1'b0;
         wb_rw_q      <= 1'b0;
         wb_rd_q      <= '0;
      end else begin
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         cap_m2r_q    <= cap_m2r_d;
         cap_rw_q     <= cap_rw_d;
         cap_rd_q     <= cap_rd_d;
         cap_load_q   <= cap_load_d;
         wb_valid_q   <= wb_valid_d;
         wb_rdata_q   <= wb_rdata_d;
         wb_alu_q     <= wb_alu_d;
         wb_m2r_q     <= wb_m2r_d;
         wb_rw_q      <= wb_rw_d;
         wb_rd_q      <= wb_rd_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   // Access-cycle counter and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         mem_error_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         mem_error_q <= mem_error_d;
      end
   end

   assign mem_error = mem_error_q;
`else
   assign mem_error = 1'b0;
`endif

   assign mem_stall        = (state_q == ST_ACCESS);
   assign dbg_state_o      = state_q;
   assign dmem_req         = dmem_req_q;
   assign dmem_we          = dmem_we_q;
   assign dmem_addr        = dmem_addr_q;
   assign dmem_wdata       = dmem_wdata_q;
   assign wb_valid         = wb_valid_q;
   assign wb_read_data_mem = wb_rdata_q;
   assign wb_alu_result    = wb_alu_q;
   assign wb_mem_to_reg    = wb_m2r_q;
   assign wb_reg_write     = wb_rw_q;
   assign wb_rd            = wb_rd_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage of the 16-bit RISC core. Sits between the execute stage and the write-back mux.
- Runs one data-memory load or store per instruction over a req/ack handshake.
- Registers the ALU result, the load data and the control bits into the MEM/WB outputs that feed write-back.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
DATA_W, 16, data and address width
RD_W, 3, destination register index width
TIMEOUT_CYCLES, 15, ACCESS cycles without ack before abort (only used with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ex_valid  in  1  execute stage presents an instruction
ex_alu_result  in  DATA_W  ALU result / memory address
ex_store_data  in  DATA_W  store data
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_mem_to_reg  in  1  write-back select (1 = memory data)
ex_reg_write  in  1  register-file write enable
ex_rd  in  RD_W  destination register
mem_stall  out  1  upstream must hold its outputs
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  DATA_W  address
dmem_wdata  out  DATA_W  write data
dmem_rdata  in  DATA_W  read data, valid with dmem_ack
dmem_ack  in  1  transaction complete
wb_valid  out  1  write-back outputs valid this cycle
wb_read_data_mem  out  DATA_W  load data
wb_alu_result  out  DATA_W  ALU result
wb_mem_to_reg  out  1  forwarded select
wb_reg_write  out  1  forwarded write enable
wb_rd  out  RD_W  forwarded destination
mem_error  out  1  sticky timeout flag

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and drives every registered output to 0 (dmem_*, wb_*, mem_error). This applies mid-transaction: dmem_req drops immediately.
- FSM has two states, IDLE and ACCESS.
- mem_stall = (state == ACCESS). It is combinational and includes the ack cycle.
- IDLE, ex_valid=0:
  - Next cycle wb_valid=0.
  - wb_* data holds its last value.
- IDLE, ex_valid=1, no memory op (mem_read=mem_write=0):
  - Next edge loads wb_alu_result, wb_mem_to_reg, wb_reg_write and wb_rd, and sets wb_valid=1 for one cycle.
  - wb_read_data_mem holds its last value.
  - Latency 1.
- IDLE, ex_valid=1, memory op:
  - Next edge captures the control bits and sets dmem_req=1, dmem_addr=ex_alu_result, dmem_we=ex_mem_write, dmem_wdata=ex_store_data.
  - State goes to ACCESS. wb_valid=0 (bubble).
  - If mem_read and mem_write are both 1, treat as a store.
- ACCESS:
  - dmem_addr, dmem_we and dmem_wdata are held stable. ex_* inputs are ignored.
  - When dmem_ack is sampled 1, the edge does the following:
    - clears dmem_req;
    - latches dmem_rdata into wb_read_data_mem (loads only; stores leave it unchanged);
    - sets wb_valid=1 with the captured control bits;
    - returns to IDLE.
- Minimum memory-op latency: accept at T, dmem_req high at T+1, ack at T+1, wb_valid at T+2.
- The instruction held upstream during ACCESS is accepted in the first IDLE cycle. It is never lost or duplicated.
- dmem_ack while in IDLE is ignored.
- wb_valid is never high for two consecutive cycles from the same instruction.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An ACCESS-cycle counter clears on entry to ACCESS.
  - If the count reaches TIMEOUT_CYCLES with no ack, the next edge clears dmem_req, returns to IDLE, and pulses wb_valid=1 with wb_reg_write forced to 0.
  - mem_error is set and stays set until reset.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- Undefined: the stage waits indefinitely for ack. mem_error is tied to 0. No counter logic is present.

Test Plan:
- ALU op: ex_valid=1, alu_result=0x1234, reg_write=1, rd=5 in IDLE -> next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=5, mem_stall stays 0.
- Load, ack after 3 cycles: addr 0x0040, rdata=0xBEEF -> dmem_req high 3 cycles with addr 0x0040 and we=0; mem_stall high for those 3 cycles; wb_read_data_mem=0xBEEF and wb_valid=1 on the cycle after ack.
- Store, then an ALU op held upstream: store 0xA5A5 to 0x0010, ack on the first ACCESS cycle -> dmem_we=1 and wdata=0xA5A5; store wb_valid pulse, then the ALU op's wb_valid on the following accepted cycle; exactly two wb_valid pulses.
- rst_n pulled low during ACCESS with dmem_req=1 -> dmem_req, wb_valid and mem_stall go 0 immediately (asynchronously); after release the stage is IDLE and accepts a new op.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted -> dmem_req drops after 4 ACCESS cycles; wb_valid=1 with wb_reg_write=0; mem_error=1 and stays 1; the next ALU op completes normally.
